spi_rx_framer: RTL and testbench
================================

// Module: spi_rx_framer
// PURPOSE
//  Downstream consumer of the SPI master receive path. Captures each received byte
//  (data_out/new_data) and packs BYTES_PER_WORD bytes MSB-first into words.
//  Frames words by transaction (busy high->low) and buffers them in a show-ahead FIFO
//  with valid/ready output, so user logic can drain at its own rate.
// PARAMETERS
//  BYTES_PER_WORD  2   bytes packed per output word (>=1); first received byte -> MSB
//  DEPTH           16  FIFO entries, power of 2 (>=2)
// PORTS
//  sysclk        in   1                   clock; all logic on posedge
//  rst           in   1                   synchronous, active-high reset
//  rx_byte       in   8                   received byte from SPI master (data_out)
//  rx_new_data   in   1                   byte-ready flag from master; may be held high >1 cycle
//  rx_busy       in   1                   master transaction-in-progress flag
//  word_out      out  8*BYTES_PER_WORD    FIFO head word
//  word_nbytes   out  clog2(BPW+1)        valid bytes in word_out (1..BPW); rest zero-padded, low bytes
//  word_last     out  1                   head word is final word of its transaction
//  word_valid    out  1                   FIFO non-empty
//  word_ready    in   1                   consumer accepts head when word_valid & word_ready
//  fifo_count    out  clog2(DEPTH)+1      entries stored (0..DEPTH)
//  overflow      out  1                   sticky: a push was dropped because FIFO full
//  clear_ovf     in   1                   clears overflow (set wins if same cycle)
// BEHAVIOUR
//  Reset: all outputs 0 (word_out, word_nbytes, word_last, word_valid, fifo_count, overflow);
//   FIFO emptied, packer discarded, FSM -> IDLE, edge registers nd_q=0, busy_q=0.
//  Byte strobe = rx_new_data & ~nd_q (rising edge only; level hold never double-counts).
//  EOF strobe  = busy_q & ~rx_busy (falling edge of rx_busy).
//  Packer: shift reg + byte index idx; each strobe shifts rx_byte in at LSB side so
//   after BPW bytes the first byte occupies [8*BPW-1 -: 8].
//  FSM states:
//   IDLE    : byte -> load, idx=1; -> HOLD if BPW==1 else COLLECT. EOF alone ignored.
//   COLLECT : byte -> pack, idx+1; if idx+1==BPW -> HOLD.
//             EOF (no byte) -> push partial, nbytes=idx, last=1, left-justified -> IDLE.
//             byte+EOF same cycle -> push word incl. byte, nbytes=idx+1, last=1 -> IDLE.
//   HOLD    : full word held pending framing decision.
//             byte -> push held (nbytes=BPW,last=0), load new byte -> COLLECT/HOLD.
//             EOF -> push held, last=1 -> IDLE.
//             byte+EOF -> push held last=0, load byte, set eof_pend -> COLLECT;
//             next cycle eof_pend forces partial push last=1 -> IDLE, clears eof_pend.
//  At most one push per cycle. A word reaches word_valid 1 cycle after its push cycle.
//  FIFO: registered pointers (clog2(DEPTH) bits, wrap modulo DEPTH) + count.
//   pop = word_valid & word_ready. push when full accepted only if pop same cycle;
//   otherwise dropped, overflow<=1, FSM advances as if accepted (no stall upstream).
//   push+pop when empty: push stored, pop ignored (word_valid was 0).
//  word_out/word_nbytes/word_last are don't-care-stable: hold head entry while !pop.
//  Reset mid-frame: partial word lost, no last emitted; next byte starts a new frame.
// TESTING
//  T1 BPW=2: bytes A5,3C, then EOF -> one word 16'hA53C, nbytes=2, last=1, count 1.
//  T2 bytes 11,22,33 then EOF -> words 16'h1122 last=0, 16'h3300 nbytes=1 last=1.
//  T3 rx_new_data held high 5 cycles with byte 7E, BPW=1 -> exactly one word 8'h7E.
//  T4 word_ready=0, push DEPTH+1 words -> count=DEPTH, overflow=1, head = first word;
//     clear_ovf -> overflow=0; drain returns first DEPTH words in order.
//  T5 HOLD with byte 44 and EOF same cycle (held 16'h1234) -> 16'h1234 last=0,
//     next cycle 16'h4400 nbytes=1 last=1.
//  T6 rst asserted after one byte of frame -> all outputs 0 next cycle; next frame clean.

Source files
------------

// File: rtl/spi_rx_framer_if.sv
// spi_rx_framer_if: SPI receive byte stream in, packed word stream out.
// master = framer side, slave = SPI master / consumer side.
interface spi_rx_framer_if #(
  parameter int BPW   = 2,
  parameter int DEPTH = 16
);
  localparam int NBW = $clog2(BPW + 1);
  localparam int CW  = $clog2(DEPTH) + 1;

  logic [7:0]       rx_byte;
  logic             rx_new_data;
  logic             rx_busy;
  logic [8*BPW-1:0] word_out;
  logic [NBW-1:0]   word_nbytes;
  logic             word_last;
  logic             word_valid;
  logic             word_ready;
  logic [CW-1:0]    fifo_count;
  logic             overflow;
  logic             clear_ovf;

  modport master (
    input  rx_byte, rx_new_data, rx_busy,
    input  word_ready, clear_ovf,
    output word_out, word_nbytes, word_last,
    output word_valid, fifo_count, overflow
  );

  modport slave (
    output rx_byte, rx_new_data, rx_busy,
    output word_ready, clear_ovf,
    input  word_out, word_nbytes, word_last,
    input  word_valid, fifo_count, overflow
  );
endinterface

// File: rtl/spi_rx_framer.sv
// spi_rx_framer: packs SPI rx bytes MSB-first into words, frames them
// on rx_busy falling, buffers in a show-ahead FIFO with valid/ready.
// Ports: sysclk, rst (sync, active-high), bus (spi_rx_framer_if.master):
//   rx_byte/rx_new_data/rx_busy in; word_out/word_nbytes/word_last/
//   word_valid out, word_ready in; fifo_count/overflow out, clear_ovf in.
module spi_rx_framer #(
  parameter int BYTES_PER_WORD = 2,
  parameter int DEPTH          = 16
) (
  input logic             sysclk,
  input logic             rst,
  spi_rx_framer_if.master bus
);
  localparam int BPW = BYTES_PER_WORD;
  localparam int WW  = 8 * BPW;
  localparam int NBW = $clog2(BPW + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [NBW-1:0] NB_ONE  = NBW'(1);
  localparam logic [NBW-1:0] NB_FULL = NBW'(BPW);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE, COLLECT, HOLD
  } state_t;

  typedef struct packed {
    logic [WW-1:0]  word;
    logic [NBW-1:0] nbytes;
    logic           last;
  } ent_t;

  state_t         state_q, state_d;
  logic [WW-1:0]  sh_q, sh_d;
  logic [NBW-1:0] idx_q, idx_d;
  logic           pend_q, pend_d;
  logic           nd_q, busy_q;
  logic [PW-1:0]  wr_q, wr_d;
  logic [PW-1:0]  rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  ent_t           mem_q [DEPTH];

  logic           byte_stb, eof_stb;
  logic           push, pop, wr, drop, full;
  logic [WW-1:0]  push_sh, load_sh, pack_sh;
  logic [NBW-1:0] push_n, idx_inc;
  logic           push_last;
  ent_t           push_ent, head;

  assign byte_stb = bus.rx_new_data & ~nd_q;
  assign eof_stb  = busy_q & ~bus.rx_busy;
  assign load_sh  = WW'(bus.rx_byte);
  assign pack_sh  = (sh_q << 8) | WW'(bus.rx_byte);
  assign idx_inc  = idx_q + NB_ONE;

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    push      = 1'b0;
    push_sh   = sh_q;
    push_n    = idx_q;
    push_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (byte_stb && eof_stb) begin
          push      = 1'b1;
          push_sh   = load_sh;
          push_n    = NB_ONE;
          push_last = 1'b1;
        end else if (byte_stb) begin
          sh_d    = load_sh;
          idx_d   = NB_ONE;
          state_d = (BPW == 1) ? HOLD : COLLECT;
        end
      end
      COLLECT: begin
        if (pend_q) begin
          // deferred end of frame left over from a HOLD byte+EOF
          push      = 1'b1;
          push_last = 1'b1;
          pend_d    = 1'b0;
          state_d   = IDLE;
        end else if (byte_stb && eof_stb) begin
          push      = 1'b1;
          push_sh   = pack_sh;
          push_n    = idx_inc;
          push_last = 1'b1;
          state_d   = IDLE;
        end else if (byte_stb) begin
          sh_d  = pack_sh;
          idx_d = idx_inc;
          if (idx_inc == NB_FULL) state_d = HOLD;
        end else if (eof_stb) begin
          push      = 1'b1;
          push_last = 1'b1;
          state_d   = IDLE;
        end
      end
      HOLD: begin
        push_n = NB_FULL;
        if (byte_stb) begin
          push    = 1'b1;
          sh_d    = load_sh;
          idx_d   = NB_ONE;
          pend_d  = eof_stb;
          state_d = (BPW == 1 && !eof_stb) ? HOLD : COLLECT;
        end else if (eof_stb) begin
          push      = 1'b1;
          push_last = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // left-justify: unused low bytes come out as zero
  always_comb begin
    push_ent.word   = push_sh << (8 * (BPW - int'(push_n)));
    push_ent.nbytes = push_n;
    push_ent.last   = push_last;
  end

  assign full = (cnt_q == CNT_MAX);
  assign pop  = bus.word_valid & bus.word_ready;
  assign wr   = push & (~full | pop);
  assign drop = push & full & ~pop;

  always_comb begin
    wr_d  = wr  ? wr_q + PW'(1) : wr_q;
    rd_d  = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(wr) - CW'(pop);
    ovf_d = ovf_q;
    if (bus.clear_ovf) ovf_d = 1'b0;
    if (drop)          ovf_d = 1'b1;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      nd_q    <= 1'b0;
      busy_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      nd_q    <= bus.rx_new_data;
      busy_q  <= bus.rx_busy;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge sysclk) begin
    if (wr) mem_q[wr_q] <= push_ent;
  end

  // head gated by valid so an empty FIFO presents all zeros
  assign head            = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign bus.word_out    = head.word;
  assign bus.word_nbytes = head.nbytes;
  assign bus.word_last   = head.last;
  assign bus.word_valid  = (cnt_q != '0);
  assign bus.fifo_count  = cnt_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_spi_rx_framer.sv
// tb_spi_rx_framer: directed + randomized checks of spi_rx_framer
// against a byte-list framing model.
module tb_spi_rx_framer;
  localparam int BPW   = 2;
  localparam int DEPTH = 16;
  localparam int WW    = 8 * BPW;

  logic sysclk = 1'b0;
  logic rst;
  always #5 sysclk = ~sysclk;

  spi_rx_framer_if #(.BPW(BPW), .DEPTH(DEPTH)) b ();
  spi_rx_framer_if #(.BPW(1), .DEPTH(4)) b1 ();

  spi_rx_framer #(.BYTES_PER_WORD(BPW), .DEPTH(DEPTH)) dut (
    .sysclk(sysclk), .rst(rst), .bus(b.master)
  );
  spi_rx_framer #(.BYTES_PER_WORD(1), .DEPTH(4)) dut1 (
    .sysclk(sysclk), .rst(rst), .bus(b1.master)
  );

  typedef struct {
    logic [WW-1:0] w;
    int            n;
    bit            last;
  } ent_t;

  int   total = 0;
  int   bad   = 0;
  bit   rnd_rdy = 1'b0;
  logic [7:0] frm [$];
  ent_t expq [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: a full word is released by the next byte of its frame or by EOF
  task automatic m_emit(input bit last);
    ent_t e;
    e.w = '0;
    for (int i = 0; i < frm.size(); i++) e.w[WW-1-8*i -: 8] = frm[i];
    e.n    = frm.size();
    e.last = last;
    expq.push_back(e);
    frm.delete();
  endtask

  task automatic m_byte(input logic [7:0] v);
    if (frm.size() == BPW) m_emit(1'b0);
    frm.push_back(v);
  endtask

  task automatic m_eof();
    if (frm.size() > 0) m_emit(1'b1);
  endtask

  task automatic tick();
    ent_t e;
    if (rnd_rdy) b.word_ready = ($urandom_range(0, 1) == 1);
    if (b.word_valid && b.word_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_word", b.word_out, 32'hdead);
      end else begin
        e = expq.pop_front();
        check("pop_word", b.word_out, e.w);
        check("pop_nbytes", b.word_nbytes, e.n);
        check("pop_last", b.word_last, e.last);
      end
    end
    @(posedge sysclk);
    #1;
  endtask

  task automatic sof();
    b.rx_busy = 1'b1;
    tick();
  endtask

  task automatic send(input logic [7:0] v, input bit with_eof);
    b.rx_byte     = v;
    b.rx_new_data = 1'b1;
    if (with_eof) b.rx_busy = 1'b0;
    m_byte(v);
    if (with_eof) m_eof();
    tick();
    b.rx_new_data = 1'b0;
    tick();
  endtask

  task automatic eof();
    b.rx_busy = 1'b0;
    m_eof();
    tick();
  endtask

  initial begin
    int n;
    logic [7:0] v;
    rst = 1'b1;
    b.rx_byte = '0;  b.rx_new_data = 0; b.rx_busy = 0;
    b.word_ready = 0; b.clear_ovf = 0;
    b1.rx_byte = '0; b1.rx_new_data = 0; b1.rx_busy = 0;
    b1.word_ready = 0; b1.clear_ovf = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_word", b.word_out, 0);
    check("rst_nbytes", b.word_nbytes, 0);
    check("rst_last", b.word_last, 0);
    check("rst_valid", b.word_valid, 0);
    check("rst_count", b.fifo_count, 0);
    check("rst_ovf", b.overflow, 0);

    // T1
    sof(); send(8'hA5, 0); send(8'h3C, 0); eof();
    check("t1_count", b.fifo_count, 1);
    check("t1_word", b.word_out, 16'hA53C);
    check("t1_nbytes", b.word_nbytes, 2);
    check("t1_last", b.word_last, 1);
    b.word_ready = 1; tick(); tick();
    check("t1_empty", b.word_valid, 0);

    // T2
    b.word_ready = 0;
    sof(); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); eof();
    check("t2_count", b.fifo_count, 2);
    check("t2_word0", b.word_out, 16'h1122);
    check("t2_last0", b.word_last, 0);
    b.word_ready = 1; tick();
    check("t2_word1", b.word_out, 16'h3300);
    check("t2_nbytes1", b.word_nbytes, 1);
    check("t2_last1", b.word_last, 1);
    tick(); tick();

    // T5
    b.word_ready = 0;
    sof(); send(8'h12, 0); send(8'h34, 0); send(8'h44, 1);
    check("t5_count", b.fifo_count, 2);
    check("t5_word0", b.word_out, 16'h1234);
    check("t5_last0", b.word_last, 0);
    b.word_ready = 1; tick();
    check("t5_word1", b.word_out, 16'h4400);
    check("t5_nbytes1", b.word_nbytes, 1);
    check("t5_last1", b.word_last, 1);
    tick(); tick();

    // T3 on the one-byte-per-word instance
    b1.rx_busy = 1; tick();
    b1.rx_byte = 8'h7E; b1.rx_new_data = 1;
    repeat (5) tick();
    b1.rx_new_data = 0; tick();
    check("t3_held_count", b1.fifo_count, 0);
    b1.rx_busy = 0; tick(); tick();
    check("t3_count", b1.fifo_count, 1);
    check("t3_word", b1.word_out, 8'h7E);
    check("t3_nbytes", b1.word_nbytes, 1);
    check("t3_last", b1.word_last, 1);

    // T4
    b.word_ready = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      sof(); send(8'(i), 0); send(8'(i + 8'h80), 0); eof();
    end
    void'(expq.pop_back());
    check("t4_count", b.fifo_count, DEPTH);
    check("t4_ovf", b.overflow, 1);
    check("t4_head", b.word_out, 16'h0080);
    b.clear_ovf = 1; tick(); b.clear_ovf = 0;
    check("t4_ovf_clr", b.overflow, 0);
    b.word_ready = 1;
    repeat (DEPTH + 2) tick();
    check("t4_drained", b.fifo_count, 0);
    check("t4_model_left", expq.size(), 0);

    // T6
    b.word_ready = 0;
    sof(); send(8'h99, 0); eof();
    sof(); send(8'h55, 0);
    rst = 1; frm.delete(); expq.delete();
    tick();
    rst = 0;
    check("t6_valid", b.word_valid, 0);
    check("t6_count", b.fifo_count, 0);
    check("t6_word", b.word_out, 0);
    check("t6_nbytes", b.word_nbytes, 0);
    check("t6_last", b.word_last, 0);
    check("t6_ovf", b.overflow, 0);
    eof(); tick();
    b.word_ready = 1;
    sof(); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0); eof();
    repeat (4) tick();
    check("t6_clean_left", expq.size(), 0);

    // randomized frames, random consumer back-pressure
    rnd_rdy = 1;
    for (int f = 0; f < 40; f++) begin
      sof();
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) begin
        v = 8'($urandom_range(0, 255));
        send(v, (k == n - 1) && ($urandom_range(0, 3) == 0));
        repeat ($urandom_range(0, 3)) tick();
      end
      if (b.rx_busy) eof();
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd_rdy = 0; b.word_ready = 1;
    repeat (DEPTH + 4) tick();
    check("rnd_model_left", expq.size(), 0);
    check("rnd_count", b.fifo_count, 0);
    check("rnd_ovf", b.overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
